// File: rtl/e_mdu.sv
// e_mdu -- E-stage multiply/divide unit with HI/LO registers.
//
// Purpose:
//   Runs MULT/MULTU/DIV/DIVU as a fixed-latency multi-cycle operation.
//   MULT/MULTU take 5 busy cycles and DIV/DIVU take 10. The result is
//   written into HI/LO on the edge that ends the last busy cycle.
//   MTHI/MTLO write E_V1 at the end of their cycle. MFHI/MFLO read the
//   committed HI/LO registers, never an in-flight result.
//
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   E_MDUOp     in   [3:0] 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//                         5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, other NONE
//   E_V1        in   [DATA_W-1:0] rs operand (already forwarded)
//   E_V2        in   [DATA_W-1:0] rt operand (already forwarded)
//   Req         in   exception/interrupt taken; kills the E-stage op
//   E_MDUStart  out  multiply/divide accepted this cycle (combinational)
//   E_MDUBusy   out  operation in flight (registered)
//   E_MDUOut    out  [DATA_W-1:0] HI for MFHI, LO for MFLO, else 0
//
// Hazard unit: stall D when the D-stage instruction is an MDU op and
// (E_MDUStart || E_MDUBusy). A start/MT* op that arrives while busy is
// ignored here.
//
// Configuration macro MDU_ZERO_DELAY_EN: when defined, multiply/divide
// commit at the end of the start cycle and E_MDUBusy stays 0.
module e_mdu #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        E_MDUOp,
    input  logic [DATA_W-1:0] E_V1,
    input  logic [DATA_W-1:0] E_V2,
    input  logic              Req,
    output logic              E_MDUStart,
    output logic              E_MDUBusy,
    output logic [DATA_W-1:0] E_MDUOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    // Returns {write_enable, hi, lo}. A zero divisor returns write_enable=0,
    // so HI/LO keep their values. The most negative value divided by -1 is
    // handled explicitly: the quotient wraps back to itself and the
    // remainder is 0.
    function automatic logic [2*DATA_W:0] mdu_calc(
        input logic [3:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic signed [2*DATA_W-1:0] sa_w;
        logic signed [2*DATA_W-1:0] sb_w;
        logic signed [2*DATA_W-1:0] sp;
        logic        [2*DATA_W-1:0] up;
        logic signed [DATA_W-1:0]   sa;
        logic signed [DATA_W-1:0]   sb;
        logic signed [DATA_W-1:0]   sq;
        logic signed [DATA_W-1:0]   sr;
        logic        [DATA_W-1:0]   uq;
        logic        [DATA_W-1:0]   ur;
        sa_w = {{DATA_W{a[DATA_W-1]}}, a};
        sb_w = {{DATA_W{b[DATA_W-1]}}, b};
        sp   = '0;
        up   = '0;
        sa   = a;
        sb   = b;
        sq   = '0;
        sr   = '0;
        uq   = '0;
        ur   = '0;
        mdu_calc = '0;
        case (op)
            OP_MULT: begin
                sp = sa_w * sb_w;
                mdu_calc = {1'b1, sp};
            end
            OP_MULTU: begin
                up = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
                mdu_calc = {1'b1, up};
            end
            OP_DIV: begin
                if (b != '0) begin
                    if (b == '1) begin
                        sq = -sa;
                        sr = '0;
                    end else begin
                        sq = sa / sb;
                        sr = sa % sb;
                    end
                    mdu_calc = {1'b1, sr, sq};
                end
            end
            OP_DIVU: begin
                if (b != '0) begin
                    uq = a / b;
                    ur = a % b;
                    mdu_calc = {1'b1, ur, uq};
                end
            end
            default: ;
        endcase
    endfunction

    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              vld_p0;
    logic              is_md;
    logic              mthi_go;
    logic              mtlo_go;
    logic [2*DATA_W:0] res;

`ifndef MDU_ZERO_DELAY_EN
    logic [3:0]        op_p0;
    logic [DATA_W-1:0] a_p0;
    logic [DATA_W-1:0] b_p0;
    logic [3:0]        cnt_p0;
`endif

    always_comb begin
        is_md      = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU) ||
                     (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
        E_MDUStart = is_md && !Req && !vld_p0;
        mthi_go    = (E_MDUOp == OP_MTHI) && !Req && !vld_p0;
        mtlo_go    = (E_MDUOp == OP_MTLO) && !Req && !vld_p0;
        E_MDUOut   = '0;
        if (E_MDUOp == OP_MFHI) E_MDUOut = hi;
        if (E_MDUOp == OP_MFLO) E_MDUOut = lo;
    end

    assign E_MDUBusy = vld_p0;

`ifdef MDU_ZERO_DELAY_EN
    assign res = mdu_calc(E_MDUOp, E_V1, E_V2);
`else
    assign res = mdu_calc(op_p0, a_p0, b_p0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hi     <= '0;
            lo     <= '0;
            vld_p0 <= 1'b0;
`ifndef MDU_ZERO_DELAY_EN
            op_p0  <= '0;
            a_p0   <= '0;
            b_p0   <= '0;
            cnt_p0 <= '0;
`endif
        end else begin
`ifdef MDU_ZERO_DELAY_EN
            vld_p0 <= 1'b0;
            if (E_MDUStart && res[2*DATA_W]) begin
                hi <= res[2*DATA_W-1:DATA_W];
                lo <= res[DATA_W-1:0];
            end
`else
            // Stage p0: operands captured at the start edge. The counter
            // holds the number of busy cycles left, including the current one.
            if (E_MDUStart) begin
                op_p0  <= E_MDUOp;
                a_p0   <= E_V1;
                b_p0   <= E_V2;
                cnt_p0 <= ((E_MDUOp == OP_DIV) || (E_MDUOp == OP_DIVU)) ? 4'd10 : 4'd5;
                vld_p0 <= 1'b1;
            end else if (vld_p0) begin
                if (cnt_p0 == 4'd1) begin
                    vld_p0 <= 1'b0;
                    cnt_p0 <= '0;
                    if (res[2*DATA_W]) begin
                        hi <= res[2*DATA_W-1:DATA_W];
                        lo <= res[DATA_W-1:0];
                    end
                end else begin
                    cnt_p0 <= cnt_p0 - 4'd1;
                end
            end
`endif
            if (mthi_go) hi <= E_V1;
            if (mtlo_go) lo <= E_V1;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
module tb_e_mdu;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  E_MDUOp = NONE;
    logic [31:0] E_V1 = '0;
    logic [31:0] E_V2 = '0;
    logic        Req = 1'b0;
    logic        E_MDUStart;
    logic        E_MDUBusy;
    logic [31:0] E_MDUOut;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    e_mdu #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDUOp    (E_MDUOp),
        .E_V1       (E_V1),
        .E_V2       (E_V2),
        .Req        (Req),
        .E_MDUStart (E_MDUStart),
        .E_MDUBusy  (E_MDUBusy),
        .E_MDUOut   (E_MDUOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every MFHI/MFLO cycle consumes one expected value.
    always @(negedge clk) begin
        if (!reset && (E_MDUOp == MFHI || E_MDUOp == MFLO)) begin
            if (exp_q.size() == 0) begin
                chk("sb_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                chk(tag_q.pop_front(), E_MDUOut, exp_q.pop_front());
            end
        end
    end

    // One clock cycle: drive just after the rising edge, return at the
    // falling edge so the caller samples mid-cycle.
    task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq, input logic rs);
        @(posedge clk);
        #1;
        reset   = rs;
        E_MDUOp = op;
        E_V1    = a;
        E_V2    = b;
        Req     = rq;
        @(negedge clk);
    endtask

    task automatic mfhi(input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        cyc(MFHI, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic mflo(input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        cyc(MFLO, '0, '0, 1'b0, 1'b0);
    endtask

    // Start an op, then read HI (expecting the old value) through the
    // whole busy window, checking busy every cycle.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] prev_hi, input string tag);
        cyc(op, a, b, 1'b0, 1'b0);
        chk({tag, "_start"}, 32'(E_MDUStart), 32'd1);
        chk({tag, "_busyT"}, 32'(E_MDUBusy), 32'd0);
        for (int i = 1; i <= n; i++) begin
            mfhi(prev_hi, {tag, "_oldhi"});
            chk({tag, "_busy"}, 32'(E_MDUBusy), 32'd1);
        end
    endtask

    // Read back LO then HI; the first read is cycle T+N+1.
    task automatic rd(input logic [31:0] eh, input logic [31:0] el, input string tag);
        mflo(el, {tag, "_lo"});
        chk({tag, "_busy_end"}, 32'(E_MDUBusy), 32'd0);
        mfhi(eh, {tag, "_hi"});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        cyc(NONE, '0, '0, 1'b0, 1'b1);
        cyc(NONE, '0, '0, 1'b0, 1'b1);
        cyc(NONE, '0, '0, 1'b0, 1'b0);
        chk("rst_busy", 32'(E_MDUBusy), 32'd0);
        mfhi(32'h0, "rst_hi");
        mflo(32'h0, "rst_lo");

        run_md(MULT, 32'hFFFFFFFE, 32'd3, 5, 32'h0, "mult_neg");
        rd(32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg");

        run_md(DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, "div_neg");
        rd(32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");

        run_md(DIVU, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, "divu");
        rd(32'h1, 32'h7FFFFFFC, "divu");

        run_md(DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h1, "div_ovf");
        rd(32'h0, 32'h80000000, "div_ovf");

        run_md(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'h0, "multu_max");
        rd(32'hFFFFFFFE, 32'h00000001, "multu_max");

        run_md(MULT, 32'h80000000, 32'h80000000, 5, 32'hFFFFFFFE, "mult_min");
        rd(32'h40000000, 32'h0, "mult_min");

        run_md(DIV, 32'd7, 32'hFFFFFFFE, 10, 32'h40000000, "div_negdiv");
        rd(32'h1, 32'hFFFFFFFD, "div_negdiv");

        // MTHI/MTLO write at end of cycle, no busy period.
        cyc(MTHI, 32'h1234, '0, 1'b0, 1'b0);
        cyc(MTLO, 32'h5678, '0, 1'b0, 1'b0);
        chk("mt_busy", 32'(E_MDUBusy), 32'd0);
        rd(32'h1234, 32'h5678, "mt");

        // Divide by zero with an MTLO attempted mid-operation.
        cyc(DIVU, 32'd5, 32'd0, 1'b0, 1'b0);
        chk("div0_start", 32'(E_MDUStart), 32'd1);
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) cyc(MTLO, 32'hBEEF, '0, 1'b0, 1'b0);
            else        cyc(NONE, '0, '0, 1'b0, 1'b0);
            chk("div0_busy", 32'(E_MDUBusy), 32'd1);
        end
        rd(32'h1234, 32'h5678, "div0");

        // Req in the start cycle kills the op and an MTHI.
        cyc(MULTU, 32'h10000, 32'h10000, 1'b1, 1'b0);
        chk("req_start", 32'(E_MDUStart), 32'd0);
        cyc(MTHI, 32'hDEAD, '0, 1'b1, 1'b0);
        chk("req_nobusy", 32'(E_MDUBusy), 32'd0);
        rd(32'h1234, 32'h5678, "req_kill");

        // Req during busy does not abort.
        cyc(MULTU, 32'h10000, 32'h10000, 1'b0, 1'b0);
        chk("req_mid_start", 32'(E_MDUStart), 32'd1);
        for (int i = 1; i <= 5; i++) begin
            cyc(NONE, '0, '0, (i == 2), 1'b0);
            chk("req_mid_busy", 32'(E_MDUBusy), 32'd1);
        end
        rd(32'h1, 32'h0, "req_mid");

        // Reset mid-divide; a MULT while busy is ignored.
        cyc(DIV, 32'd100, 32'd7, 1'b0, 1'b0);
        cyc(MULT, 32'd3, 32'd3, 1'b0, 1'b0);
        chk("busy_mult_start", 32'(E_MDUStart), 32'd0);
        chk("busy_mult_busy", 32'(E_MDUBusy), 32'd1);
        cyc(NONE, '0, '0, 1'b0, 1'b0);
        cyc(NONE, '0, '0, 1'b0, 1'b1);
        mfhi(32'h0, "mid_rst_hi");
        chk("mid_rst_busy", 32'(E_MDUBusy), 32'd0);
        mflo(32'h0, "mid_rst_lo");
        for (int i = 0; i < 12; i++) begin
            cyc(NONE, '0, '0, 1'b0, 1'b0);
            chk("mid_rst_idle", 32'(E_MDUBusy), 32'd0);
        end
        rd(32'h0, 32'h0, "mid_rst_late");

        // Reset and start in the same cycle: reset wins.
        cyc(MTLO, 32'h77, '0, 1'b0, 1'b0);
        cyc(MULT, 32'd2, 32'd3, 1'b0, 1'b1);
        cyc(NONE, '0, '0, 1'b0, 1'b0);
        chk("rst_start_busy", 32'(E_MDUBusy), 32'd0);
        for (int i = 0; i < 6; i++) cyc(NONE, '0, '0, 1'b0, 1'b0);
        rd(32'h0, 32'h0, "rst_start");

        cyc(NONE, '0, '0, 1'b0, 1'b0);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- E_MDUOp  in  4  operation code: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; others = NONE
- E_V1  in  32  rs operand, already forwarded
- E_V2  in  32  rt operand, already forwarded
- Req  in  1  exception/interrupt taken this cycle; kills the E-stage instruction
- E_MDUStart  out  1  combinational: current op is MULT/MULTU/DIV/DIVU, Req=0, E_MDUBusy=0
- E_MDUBusy  out  1  registered: multi-cycle operation in flight
- E_MDUOut  out  32  combinational: HI for MFHI, LO for MFLO, else 0

Function
REQ-003 SHALL hold internal 32-bit HI and LO registers and a 4-bit down-counter.
REQ-004 SHALL latch E_V1, E_V2 and the op at the rising edge that ends a cycle with E_MDUStart=1 (the start cycle T).
REQ-005 SHALL set E_MDUBusy=1 for cycles T+1..T+N, with N=5 for MULT/MULTU and N=10 for DIV/DIVU.
REQ-006 SHALL write HI/LO at the edge ending cycle T+N and clear E_MDUBusy at that same edge; MFHI/MFLO in cycle T+N+1 SHALL read the new values.
REQ-007 MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned 64-bit product.
REQ-008 DIV: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
REQ-009 Divisor 0 SHALL still take 10 busy cycles and SHALL leave HI and LO unchanged.
REQ-010 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-011 MTHI/MTLO with Req=0 SHALL write E_V1 into HI/LO at the end of the cycle; no busy period.
REQ-012 The start/MT* op SHALL be ignored if it arrives while E_MDUBusy=1; upstream stall logic is responsible for preventing this.
REQ-013 Req=1 SHALL suppress start, MTHI and MTLO in that cycle.
REQ-014 Req=1 while E_MDUBusy=1 SHALL NOT abort the in-flight operation; it completes on schedule.
REQ-015 E_MDUOut SHALL reflect HI/LO register contents only, never in-flight results.
REQ-016 Stall rule for the hazard unit: stall D when the D-stage instruction is an MDU op and (E_MDUStart or E_MDUBusy).

Reset
REQ-017 On reset=1 at a rising edge: HI=0, LO=0, counter=0, E_MDUBusy=0, latched operands/op cleared.
REQ-018 Reset SHALL override everything, including mid-operation: no pending HI/LO write survives reset.
REQ-019 Reset and a start in the same cycle: reset wins and no operation begins.

Configuration
REQ-020 Macro MDU_ZERO_DELAY_EN, when defined: MULT/MULTU/DIV/DIVU SHALL write HI/LO at the edge ending the start cycle, E_MDUBusy SHALL stay 0, and E_MDUStart keeps its definition.
REQ-021 Without MDU_ZERO_DELAY_EN: latencies SHALL be exactly as in REQ-005/REQ-006.

Verification
REQ-022 MULT E_V1=0xFFFFFFFE, E_V2=3 at cycle T -> busy in T+1..T+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO in T+6 outputs 0xFFFFFFFA.
REQ-023 DIV 0xFFFFFFF9 (-7) / 2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-024 MTHI 0x1234, then DIVU 5/0 -> HI=0x1234 unchanged after 10 busy cycles; LO unchanged.
REQ-025 MULTU 0x10000*0x10000 with Req=1 in the start cycle -> E_MDUStart=0, busy never set, HI/LO unchanged; the same op with Req=0, then Req=1 at T+2 -> completes with HI=1, LO=0.
REQ-026 Assert reset at T+3 of a DIV -> next cycle busy=0, HI=LO=0; a MULT issued at T+1 while busy -> ignored.
